ram_rr_arbiter: RTL and testbench
=================================

// Module: ram_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one single-port synchronous RAM between two requesters (A, B).
//  Accepts one read or write command at a time, drives the RAM RdEn/WrEn/Address/WrData for exactly
//  one cycle, captures RdData and returns a completion pulse to the owning requester.
//  Sits between client logic and the RAM; the only block allowed to drive the RAM control port.
// PARAMETERS
//  ADDRESS  3   RAM address width (bits)
//  WIDTH    16  RAM data width (bits)
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  a_req        in   1        requester A command valid; held with payload until a_gnt
//  a_we         in   1        A: 1 = write, 0 = read
//  a_addr       in   ADDRESS  A: RAM address
//  a_wdata      in   WIDTH    A: write data (ignored for reads)
//  a_gnt        out  1        A: command accepted this cycle (combinational)
//  a_done       out  1        A: one-cycle completion pulse (registered)
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_done   same as A, for requester B
//  rsp_rdata    out  WIDTH    read data, valid while a_done or b_done is high for a read; 0 after a write
//  ram_RdEn     out  1        to RAM RdEn (registered)
//  ram_WrEn     out  1        to RAM WrEn (registered)
//  ram_Address  out  ADDRESS  to RAM Address (registered)
//  ram_WrData   out  WIDTH    to RAM WrData (registered)
//  ram_RdData   in   WIDTH    from RAM RdData (RAM registers it on the edge that samples RdEn)
// BEHAVIOUR
//  FSM states: IDLE -> CMD -> CAPT -> IDLE. One command in flight; 3 cycles per command.
//  IDLE: if any req, grant one (a_gnt/b_gnt high this cycle, never both); latch we/addr/wdata and
//    owner into internal regs at the edge; -> CMD. No req: stay IDLE, all gnt low.
//  Arbitration: round-robin on last owner. If both req, the requester NOT granted last wins.
//    Only one requesting: it wins regardless of pointer. Pointer updates only on a grant.
//  CMD (1 cycle): ram_Address/ram_WrData = latched values; ram_WrEn = we, ram_RdEn = ~we.
//    Exactly one of RdEn/WrEn is high; never both. -> CAPT.
//  CAPT (1 cycle): enables low; ram_RdData valid this cycle. At the edge: rsp_rdata <= read ? ram_RdData : 0;
//    owner's done <= 1; -> IDLE.
//  done pulses exactly one cycle and coincides with IDLE; a new grant may occur in that same cycle.
//  Timing (grant in cycle N): RAM enable high in N+1, done + rsp_rdata in N+3. Next grant earliest N+3.
//  ram_RdEn/ram_WrEn low in every state except CMD. ram_Address/ram_WrData hold last value outside CMD.
//  gnt is never asserted outside IDLE; req in CMD/CAPT waits (no drop, no queue beyond the held req).
//  rsp_rdata holds its value until the next CAPT.
//  Requester dropping req before gnt: legal, no command issued. Payload change while req held before gnt:
//    sampled value at the granting cycle is used.
//  Reset (any state, including mid-command): state IDLE; a_gnt,b_gnt,a_done,b_done,ram_RdEn,ram_WrEn = 0;
//    ram_Address, ram_WrData, rsp_rdata = 0; RR pointer = B (so A wins first tie). An aborted command
//    produces no done; a write whose CMD edge coincides with rst asserted is not issued (enables forced 0).
//  Address width: addresses passed unmodified; no range check (RAM DEPTH = 2**ADDRESS).
// TESTING
//  1. After rst: A write addr 3 data 16'hBEEF -> a_gnt cycle N, ram_WrEn=1 addr 3 in N+1, a_done in N+3, rsp_rdata=0.
//  2. A read addr 3 after test 1 -> ram_RdEn=1 in N+1, a_done N+3 with rsp_rdata=16'hBEEF; b_done stays 0.
//  3. A and B req held continuously from reset -> grants alternate A,B,A,B every 3 cycles; never both gnt.
//  4. Only B requesting back-to-back reads addr 0..7 -> B granted every 3 cycles; data matches prior writes.
//  5. rst asserted during CMD of B write addr 5 data 16'h1234 -> no b_done, enables 0 next cycle,
//     later read of addr 5 does not return 16'h1234 (value unchanged from before).
//  6. Every cycle assertion: !(ram_RdEn && ram_WrEn); !(a_gnt && b_gnt); done pulses one cycle wide.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between requesters A and B.
// One command in flight: grant in IDLE, drive the RAM for one cycle in CMD, capture read data in CAPT.
//
//   state  | meaning
//   IDLE   | waiting for a request; grant is combinational here, done pulses land here
//   CMD    | RAM enable high for exactly one cycle with latched address/data
//   CAPT   | RAM read data valid; captured into rsp_rdata with the owner's done at the edge
module ram_rr_arbiter #(
    parameter int ADDRESS = 3,
    parameter int WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDRESS-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    output logic               a_gnt,
    output logic               a_done,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [ADDRESS-1:0] b_addr,
    input  logic [WIDTH-1:0]   b_wdata,
    output logic               b_gnt,
    output logic               b_done,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               ram_RdEn,
    output logic               ram_WrEn,
    output logic [ADDRESS-1:0] ram_Address,
    output logic [WIDTH-1:0]   ram_WrData,
    input  logic [WIDTH-1:0]   ram_RdData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last_b;
    logic               r_owner_b;
    logic               r_we;
    logic               r_rden;
    logic               r_wren;
    logic [ADDRESS-1:0] r_ram_addr;
    logic [WIDTH-1:0]   r_ram_wdata;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_a_done;
    logic               r_b_done;
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_sel_we;
    logic [ADDRESS-1:0] w_sel_addr;
    logic [WIDTH-1:0]   w_sel_wdata;

    always_comb begin
        w_next  = r_state;
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    // A wins a tie only when B owned the RAM last
                    if (a_req && (!b_req || r_last_b)) begin
                        w_gnt_a = 1'b1;
                    end else if (b_req) begin
                        w_gnt_b = 1'b1;
                    end
                end
                if (w_gnt_a || w_gnt_b) begin
                    w_next = S_CMD;
                end
            end
            S_CMD:   w_next = S_CAPT;
            S_CAPT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sel_we    = w_gnt_b ? b_we    : a_we;
    assign w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_b    <= 1'b1;
            r_owner_b   <= 1'b0;
            r_we        <= 1'b0;
            r_rden      <= 1'b0;
            r_wren      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rdata     <= '0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            if (w_gnt_a || w_gnt_b) begin
                r_last_b    <= w_gnt_b;
                r_owner_b   <= w_gnt_b;
                r_we        <= w_sel_we;
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
                r_wren      <= w_sel_we;
                r_rden      <= ~w_sel_we;
            end
            if (r_state == S_CAPT) begin
                r_rdata  <= r_we ? '0 : ram_RdData;
                r_a_done <= ~r_owner_b;
                r_b_done <= r_owner_b;
            end
        end
    end

    // Enables are masked by rst so a command caught by reset never reaches the RAM edge
    assign ram_RdEn    = r_rden & ~rst;
    assign ram_WrEn    = r_wren & ~rst;
    assign ram_Address = r_ram_addr;
    assign ram_WrData  = r_ram_wdata;
    assign rsp_rdata   = r_rdata;
    assign a_gnt       = w_gnt_a;
    assign b_gnt       = w_gnt_b;
    assign a_done      = r_a_done;
    assign b_done      = r_b_done;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: RAM behavioural model plus a transaction-level reference
// that predicts grants, RAM activity, completions and read data cycle by cycle.
module tb_ram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_done, b_gnt, b_done;
    logic [15:0] rsp_rdata;
    logic        ram_RdEn, ram_WrEn;
    logic [2:0]  ram_Address;
    logic [15:0] ram_WrData, ram_RdData;
    logic        env_load;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.ADDRESS(3), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done),
        .rsp_rdata(rsp_rdata),
        .ram_RdEn(ram_RdEn), .ram_WrEn(ram_WrEn),
        .ram_Address(ram_Address), .ram_WrData(ram_WrData),
        .ram_RdData(ram_RdData)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'(16'hA000 + i * 16'h0101);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Single-port synchronous RAM seen by the DUT
    logic [15:0] ram_env [8];
    always @(posedge clk) begin
        if (env_load) begin
            for (int i = 0; i < 8; i++) ram_env[i] <= init_val(i);
        end else begin
            if (ram_WrEn) ram_env[ram_Address] <= ram_WrData;
            if (ram_RdEn) ram_RdData <= ram_env[ram_Address];
        end
    end

    // Reference model: one outstanding transaction, timestamps relative to its grant cycle
    logic [15:0] mem_m [8];
    int          cyc = 0;
    bit          have_pend = 0;
    int          p_cyc = 0;
    bit          p_owner_b, p_we;
    logic [2:0]  p_addr;
    logic [15:0] p_wdata;
    bit          last_b = 1;
    logic [2:0]  exp_addr = '0;
    logic [15:0] exp_wd = '0;
    logic [15:0] exp_rdata = '0;
    bit          prev_ad = 0, prev_bd = 0;

    always @(negedge clk) begin : model
        bit e_ag, e_bg, e_ad, e_bd, e_rd, e_wr, win_b;
        if (cyc == 0) for (int i = 0; i < 8; i++) mem_m[i] = init_val(i);
        e_ag = 0; e_bg = 0; e_ad = 0; e_bd = 0; e_rd = 0; e_wr = 0;
        if (have_pend && cyc == p_cyc + 1) begin
            exp_addr = p_addr;
            exp_wd   = p_wdata;
            e_wr     = p_we && !rst;
            e_rd     = !p_we && !rst;
            if (p_we && !rst) mem_m[p_addr] = p_wdata;
        end
        if (have_pend && cyc == p_cyc + 3) begin
            e_ad      = !p_owner_b;
            e_bd      = p_owner_b;
            exp_rdata = p_we ? 16'h0 : mem_m[p_addr];
            have_pend = 0;
        end
        if (!rst && !have_pend && (a_req || b_req)) begin
            win_b = b_req && (!a_req || !last_b);
            e_ag  = !win_b;
            e_bg  = win_b;
        end
        chk("a_gnt", 32'(a_gnt), 32'(e_ag));
        chk("b_gnt", 32'(b_gnt), 32'(e_bg));
        chk("gnt_exclusive", 32'(a_gnt && b_gnt), 32'(0));
        chk("ram_RdEn", 32'(ram_RdEn), 32'(e_rd));
        chk("ram_WrEn", 32'(ram_WrEn), 32'(e_wr));
        chk("en_exclusive", 32'(ram_RdEn && ram_WrEn), 32'(0));
        chk("ram_Address", 32'(ram_Address), 32'(exp_addr));
        chk("ram_WrData", 32'(ram_WrData), 32'(exp_wd));
        chk("a_done", 32'(a_done), 32'(e_ad));
        chk("b_done", 32'(b_done), 32'(e_bd));
        chk("a_done_width", 32'(prev_ad && a_done), 32'(0));
        chk("b_done_width", 32'(prev_bd && b_done), 32'(0));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        prev_ad = a_done;
        prev_bd = b_done;
        if (e_ag || e_bg) begin
            have_pend = 1;
            p_cyc     = cyc;
            p_owner_b = e_bg;
            p_we      = e_bg ? b_we : a_we;
            p_addr    = e_bg ? b_addr : a_addr;
            p_wdata   = e_bg ? b_wdata : a_wdata;
            last_b    = e_bg;
        end
        if (rst) begin
            have_pend = 0;
            last_b    = 1;
            exp_addr  = '0;
            exp_wd    = '0;
            exp_rdata = '0;
        end
        cyc++;
    end

    task automatic set_req(input bit is_b, input bit v, input bit we,
                           input logic [2:0] addr, input logic [15:0] wd);
        if (is_b) begin b_req = v; b_we = we; b_addr = addr; b_wdata = wd; end
        else      begin a_req = v; a_we = we; a_addr = addr; a_wdata = wd; end
    endtask

    task automatic wait_gnt(input bit is_b);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(is_b ? b_gnt : a_gnt) && k < 30);
        if (k >= 30) chk("gnt_timeout", 32'(is_b ? b_gnt : a_gnt), 32'(1));
    endtask

    task automatic issue(input bit is_b, input bit we, input logic [2:0] addr, input logic [15:0] wd);
        @(posedge clk); #1;
        set_req(is_b, 1'b1, we, addr, wd);
        wait_gnt(is_b);
        @(posedge clk); #1;
        set_req(is_b, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; env_load = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; env_load = 1'b0;

        issue(1'b0, 1'b1, 3'd3, 16'hBEEF);
        chk("write_rsp_zero", 32'(rsp_rdata), 32'h0);
        issue(1'b0, 1'b0, 3'd3, 16'h0);
        chk("read_back_beef", 32'(rsp_rdata), 32'hBEEF);

        @(posedge clk); #1;
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 3'd1, 16'h1111);
        set_req(1'b1, 1'b1, 1'b1, 3'd2, 16'h2222);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) issue(1'b1, 1'b1, 3'(i), 16'(16'h5A00 + i));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set_req(1'b1, 1'b1, 1'b0, 3'(i), 16'h0);
            wait_gnt(1'b1);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (4) @(posedge clk);

        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b1, 3'd5, 16'h1234);
        wait_gnt(1'b1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        issue(1'b1, 1'b0, 3'd5, 16'h0);
        chk("aborted_write_absent", 32'(rsp_rdata == 16'h1234), 32'(0));

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 299) == 0);
            a_req   = ($urandom_range(0, 3) < ((c / 500) % 4));
            b_req   = ($urandom_range(0, 3) < (((c / 250) + 1) % 4));
            a_we    = 1'($urandom);
            b_we    = 1'($urandom);
            a_addr  = 3'($urandom);
            b_addr  = 3'($urandom);
            a_wdata = 16'($urandom);
            b_wdata = 16'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (6) @(posedge clk);
        pulse_rst();
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
